// File: rtl/delay_sensor_pkg.sv
// Shared definitions for delay-line sensors: FSM encoding, default chain
// geometry and the leading-reached depth encoder.
package delay_sensor_pkg;

    // Default geometry of the single-chain sensor
    localparam int DEF_STAGES  = 20;
    localparam int DEF_DEPTH_W = 5;

    // Widest chain the shared encoder handles; wider chains need a larger value here
    localparam int MAX_CHAIN_STAGES = 64;
    localparam int DEPTH_MAX_W      = $clog2(MAX_CHAIN_STAGES + 1);

    // Measurement FSM states, kept as plain constants for older flows
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LAUNCH  = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_SYNC    = 3'd3;
    localparam state_t ST_ENCODE  = 3'd4;
    localparam state_t ST_ACCUM   = 3'd5;
    localparam state_t ST_SETTLE  = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    // Count consecutive reached taps starting at tap 0. The first miss ends the
    // run, so later bubbles never add to the depth. Callers zero the bits above
    // their own chain length, which also terminates the run there.
    function automatic logic [DEPTH_MAX_W-1:0] depth_encode(
        input logic [MAX_CHAIN_STAGES-1:0] reached
    );
        logic [DEPTH_MAX_W-1:0] cnt;
        logic                   run;
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_CHAIN_STAGES; i++) begin
            run = run & reached[i];
            cnt = cnt + {{(DEPTH_MAX_W-1){1'b0}}, run};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/delay_chain_sensor_chain.sv
// Tapped inverter chain built from the library inverter cell. Every
// inter-stage net carries keep so synthesis cannot collapse the chain.

// Behavioural stand-in for the library inverter cell used by the chain
module not3_34 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// Chain of STAGES inverters; taps[i] is the output of stage i
module delay_chain_tapped
    import delay_sensor_pkg::*;
#(
    parameter int STAGES = DEF_STAGES
) (
    input  logic              launch,
    output logic [STAGES-1:0] taps
);

    (* keep *) logic [STAGES:0] node;

    assign node[0] = launch;

    // One inverter cell per stage, each driving the next node
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        not3_34 u_inv (
            .a (node[g]),
            .y (node[g+1])
        );
    end

    assign taps = node[STAGES:1];

endmodule

// File: rtl/delay_chain_sensor.sv
// Self-timed delay-line sensor: launches an edge into the tapped chain,
// captures the taps one clock later, converts each capture to a depth and
// returns the sum of 2**AVG_LOG2 samples over a valid/ready handshake.
module delay_chain_sensor
    import delay_sensor_pkg::*;
#(
    parameter int STAGES     = DEF_STAGES,
    parameter int DEPTH_W    = DEF_DEPTH_W,
    parameter int AVG_LOG2   = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic [DEPTH_W+AVG_LOG2-1:0] result,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        sat_seen,
    output logic [STAGES-1:0]           taps_dbg
);

    localparam int ACC_W = DEPTH_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t                      state_q;
    state_t                      state_d;
    logic                        launch_q;
    logic [STAGES-1:0]           chain_taps;
    logic [STAGES-1:0]           cap_q;
    logic [STAGES-1:0]           cap_s;
    logic [MAX_CHAIN_STAGES-1:0] reached_ext;
    logic [DEPTH_MAX_W-1:0]      depth_full;
    logic [DEPTH_W-1:0]          depth_q;
    logic [ACC_W-1:0]            acc_q;
    logic [ACC_W-1:0]            acc_next;
    logic [CNT_W-1:0]            sample_cnt_q;
    logic                        last_sample;
    logic [SET_W-1:0]            settle_cnt_q;

    // The chain input is driven only by the launch flop
    delay_chain_tapped #(
        .STAGES (STAGES)
    ) u_chain (
        .launch (launch_q),
        .taps   (chain_taps)
    );

    assign busy        = (state_q != ST_IDLE);
    assign acc_next    = acc_q + ACC_W'(depth_q);
    assign last_sample = (sample_cnt_q == CNT_W'(NSAMP - 1));

    // Sequence one measurement; start is only looked at while idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_LAUNCH;
            ST_LAUNCH:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SYNC;
            ST_SYNC:    state_d = ST_ENCODE;
            ST_ENCODE:  state_d = ST_ACCUM;
            ST_ACCUM:   state_d = last_sample ? ST_DONE : ST_SETTLE;
            ST_SETTLE:  if (settle_cnt_q == '0) state_d = ST_LAUNCH;
            ST_DONE:    if (result_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch flop toggles once per sample so rising and falling edges alternate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch_q <= 1'b0;
        end else if (state_q == ST_LAUNCH) begin
            launch_q <= ~launch_q;
        end
    end

    // Raw tap capture exactly one clock after the launch toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            cap_q <= chain_taps;
        end
    end

    // Second flop stage hardens against metastability; also feeds the debug copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_s    <= '0;
            taps_dbg <= '0;
        end else if (state_q == ST_SYNC) begin
            cap_s    <= cap_q;
            taps_dbg <= cap_q;
        end
    end

    // A tap has been reached when it shows the level the new edge leaves behind:
    // even stages invert the launch level, odd stages follow it
    always_comb begin
        reached_ext = '0;
        for (int i = 0; i < STAGES; i++) begin
            reached_ext[i] = (cap_s[i] == (launch_q ^ ~i[0]));
        end
    end

    assign depth_full = depth_encode(reached_ext);

    // Registered depth of the current sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (state_q == ST_ENCODE) begin
            depth_q <= DEPTH_W'(depth_full);
        end
    end

    // Accumulator, sample counter and saturation flag, cleared on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            sample_cnt_q <= '0;
            sat_seen     <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            acc_q        <= '0;
            sample_cnt_q <= '0;
            sat_seen     <= 1'b0;
        end else if (state_q == ST_ACCUM) begin
            acc_q        <= acc_next;
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            if (depth_q == DEPTH_W'(STAGES)) begin
                sat_seen <= 1'b1;
            end
        end
    end

    // Idle gap between a capture and the next launch lets the chain settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            settle_cnt_q <= SET_W'(SETTLE_CYC - 1);
        end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
            settle_cnt_q <= settle_cnt_q - SET_W'(1);
        end
    end

    // Result register and valid flag; the result stays put until the next measurement ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (state_q == ST_ACCUM && last_sample) begin
            result       <= acc_next;
            result_valid <= 1'b1;
        end else if (state_q == ST_DONE && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delay_chain_sensor.sv
// Bench for delay_chain_sensor: three instances (16, 2 and 1 samples per
// result); expected results go into per-instance queues and monitors compare
// them whenever a result is handed over.
module tb_delay_chain_sensor;

    typedef struct {
        logic [31:0] result;
        logic        sat;
        logic [19:0] taps;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start, start1, start0;
    logic        ready, ready1, ready0;
    logic        busy, busy1, busy0;
    logic        result_valid, rv1, rv0;
    logic        sat_seen, sat1, sat0;
    logic [8:0]  result;
    logic [5:0]  result1;
    logic [4:0]  result0;
    logic [19:0] taps_dbg, taps1, taps0;

    exp_t q_main[$];
    exp_t q_one[$];
    exp_t q_zero[$];
    exp_t e_main, e_one, e_zero;

    int vectors;
    int miscompares;
    int cyc;

    delay_chain_sensor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (ready),
        .sat_seen     (sat_seen),
        .taps_dbg     (taps_dbg)
    );

    delay_chain_sensor #(.AVG_LOG2(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start1),
        .busy         (busy1),
        .result       (result1),
        .result_valid (rv1),
        .result_ready (ready1),
        .sat_seen     (sat1),
        .taps_dbg     (taps1)
    );

    delay_chain_sensor #(.AVG_LOG2(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start0),
        .busy         (busy0),
        .result       (result0),
        .result_valid (rv0),
        .result_ready (ready0),
        .sat_seen     (sat0),
        .taps_dbg     (taps0)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected_result(input string tag);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s_unexpected: result handed over with no expectation queued", tag);
    endtask

    task automatic score(input string tag, input exp_t e, input logic [31:0] r,
                         input logic s, input logic [19:0] t);
        check_output({tag, "_result"}, r, e.result);
        check_output({tag, "_sat"}, 32'(s), 32'(e.sat));
        check_output({tag, "_taps"}, 32'(t), 32'(e.taps));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int which);
        case (which)
            0:       start  = 1'b1;
            1:       start1 = 1'b1;
            default: start0 = 1'b1;
        endcase
    endtask

    // Step until the chosen instance shows result_valid; cycles counted from the start drive
    task automatic wait_done(input int which, input int limit, output int cycles);
        logic v;
        cycles = 0;
        v      = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            start  = 1'b0;
            start1 = 1'b0;
            start0 = 1'b0;
            cycles++;
            case (which)
                0:       v = result_valid;
                1:       v = rv1;
                default: v = rv0;
            endcase
            if (v) break;
        end
        if (!v) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout_dut%0d: no result_valid after %0d cycles", which, limit);
        end
    endtask

    // Monitors: pop and compare whenever a result is handed over
    always @(negedge clk) begin
        if (rst_n && result_valid && ready) begin
            if (q_main.size() == 0) unexpected_result("main");
            else begin
                e_main = q_main.pop_front();
                score("main", e_main, 32'(result), sat_seen, taps_dbg);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rv1 && ready1) begin
            if (q_one.size() == 0) unexpected_result("avg1");
            else begin
                e_one = q_one.pop_front();
                score("avg1", e_one, 32'(result1), sat1, taps1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rv0 && ready0) begin
            if (q_zero.size() == 0) unexpected_result("avg0");
            else begin
                e_zero = q_zero.pop_front();
                score("avg0", e_zero, 32'(result0), sat0, taps0);
            end
        end
    end

    // Watchdog against a hung sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: sequence did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        ready  = 1'b0;
        ready1 = 1'b1;
        ready0 = 1'b1;

        // Reset held: a start pulse must leave everything at reset values
        repeat (3) step();
        start = 1'b1;
        step();
        @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(result_valid), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_taps", 32'(taps_dbg), 32'd0);
        check_output("rst_sat", 32'(sat_seen), 32'd0);
        step();
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();

        // Zero-delay chain, 16 samples of depth 20; last sample has level 0
        q_main.push_back('{result: 32'd320, sat: 1'b1, taps: 20'h55555});
        apply_stimulus(0);
        wait_done(0, 300, cyc);
        check_output("main_latency", 32'(cyc), 32'd111);
        check_output("main_busy_at_valid", 32'(busy), 32'd1);

        // Result must stay stable while the consumer stalls
        for (int i = 0; i < 10; i++) begin
            step();
            check_output("hold_result", 32'(result), 32'd320);
            check_output("hold_valid", 32'(result_valid), 32'd1);
        end

        // Handshake with a simultaneous start: the start is dropped
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b0;
        check_output("hs_valid_drop", 32'(result_valid), 32'd0);
        check_output("hs_busy_drop", 32'(busy), 32'd0);
        step();
        check_output("hs_start_ignored", 32'(busy), 32'd0);
        repeat (2) step();

        // Abort during sample 5 (sample 5 occupies cycles 29..35 after the start)
        apply_stimulus(0);
        step();
        start = 1'b0;
        repeat (30) step();
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_valid", 32'(result_valid), 32'd0);
        check_output("abort_result", 32'(result), 32'd0);
        check_output("abort_taps", 32'(taps_dbg), 32'd0);
        check_output("abort_sat", 32'(sat_seen), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Fresh full measurement after the abort, launch level restarted at 0
        ready = 1'b1;
        q_main.push_back('{result: 32'd320, sat: 1'b1, taps: 20'h55555});
        apply_stimulus(0);
        wait_done(0, 300, cyc);
        check_output("post_abort_latency", 32'(cyc), 32'd111);
        repeat (3) step();

        // Two samples of opposite level: taps alternate 0xAAAAA then 0x55555
        q_one.push_back('{result: 32'd40, sat: 1'b1, taps: 20'h55555});
        apply_stimulus(1);
        step();
        start1 = 1'b0;
        repeat (3) step();
        check_output("avg1_first_taps", 32'(taps1), 32'h000AAAAA);
        wait_done(1, 50, cyc);
        check_output("avg1_latency", 32'(cyc + 4), 32'd13);
        repeat (3) step();

        // Single sample, level 1: reached below tap 7, miss at 7, bubble at 12
        force dut0.chain_taps = 20'hABA2A;
        q_zero.push_back('{result: 32'd7, sat: 1'b0, taps: 20'hABA2A});
        apply_stimulus(2);
        wait_done(2, 50, cyc);
        check_output("avg0_latency", 32'(cyc), 32'd6);
        repeat (3) step();

        // Single sample, level 0: no tap reached gives depth 0
        force dut0.chain_taps = 20'hAAAAA;
        q_zero.push_back('{result: 32'd0, sat: 1'b0, taps: 20'hAAAAA});
        apply_stimulus(2);
        wait_done(2, 50, cyc);
        repeat (3) step();
        release dut0.chain_taps;

        // Unforced chain, level 1: saturated depth 20
        q_zero.push_back('{result: 32'd20, sat: 1'b1, taps: 20'hAAAAA});
        apply_stimulus(2);
        wait_done(2, 50, cyc);
        repeat (3) step();

        check_output("main_queue_drained", 32'(q_main.size()), 32'd0);
        check_output("avg1_queue_drained", 32'(q_one.size()), 32'd0);
        check_output("avg0_queue_drained", 32'(q_zero.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
